// File: rtl/ondra_tone_gen_if.sv
// ondra_tone_gen_if: control and tone-output signals of the Ondra tone generator
//   tone_sel   [2:0]  tone index, taken when tone_load is high
//   tone_load         1-cycle strobe requesting tone_sel
//   mute              level, 1 = silence and park the counter
//   mode              0 = fixed-width pulse, 1 = 50% square
//   out               registered 1-bit tone output
//   cur_tone   [2:0]  tone currently being generated
//   period_end        1-cycle strobe after the last cycle of a period
interface ondra_tone_gen_if;
    logic [2:0] tone_sel;
    logic       tone_load;
    logic       mute;
    logic       mode;
    logic       out;
    logic [2:0] cur_tone;
    logic       period_end;
    modport master (output tone_sel, tone_load, mute, mode, input out, cur_tone, period_end);
    modport slave  (input tone_sel, tone_load, mute, mode, output out, cur_tone, period_end);
endinterface

// File: rtl/ondra_tone_gen.sv
// ondra_tone_gen: 8-entry glitch-free tone generator for the Ondra SPO 186 audio path
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   bus        ondra_tone_gen_if.slave: tone_sel/tone_load/mute/mode in,
//              out/cur_tone/period_end out (all outputs registered)
module ondra_tone_gen #(
    parameter int               CLK_FREQ   = 50_000_000,
    parameter int               CNT_W      = 18,
    parameter logic [8*18-1:0]  TONE_FREQS = {18'd2000, 18'd1600, 18'd1300, 18'd1000,
                                              18'd800, 18'd600, 18'd400, 18'd0},
    parameter int               PULSE_DIV  = 4_705
) (
    input  logic            clk,
    input  logic            reset_n,
    ondra_tone_gen_if.slave bus
);
    localparam int W_RAW = CLK_FREQ / PULSE_DIV;
    localparam int W_MAX = (1 << CNT_W) - 1;
    // Pulse width saturates at the counter range; min(W, P-1) is unchanged by this.
    localparam logic [CNT_W-1:0] W = CNT_W'(W_RAW > W_MAX ? W_MAX : W_RAW);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state;
    logic [CNT_W-1:0] p_tab [8];
    logic [CNT_W-1:0] cnt, thr, p_cur, p_nt, thr_nt;
    logic [2:0]       pend_tone, nt;
    logic             pend, wrap;
    // Period lengths are fixed at elaboration so no run-time divider is needed.
    for (genvar k = 0; k < 8; k++) begin : g_p
        localparam int F = int'(TONE_FREQS[18*k +: 18]);
        localparam int D = CLK_FREQ / (F == 0 ? 1 : F);
        localparam int P = F == 0 ? 0 : (D < 2 ? 2 : D);
        assign p_tab[k] = CNT_W'(P);
    end
    // Tone to apply at the next boundary: a load this cycle beats an older pending one.
    assign nt     = bus.tone_load ? bus.tone_sel : pend ? pend_tone : bus.cur_tone;
    assign p_nt   = p_tab[nt];
    assign thr_nt = bus.mode ? p_nt >> 1 : (W < p_nt - 1'b1 ? W : p_nt - 1'b1);
    assign p_cur  = p_tab[bus.cur_tone];
    assign wrap   = cnt == p_cur - 1'b1;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            thr            <= '0;
            pend           <= 1'b0;
            pend_tone      <= '0;
            bus.out        <= 1'b0;
            bus.cur_tone   <= '0;
            bus.period_end <= 1'b0;
        end else if (state == IDLE || bus.mute) begin
            // Idle, or muted while running: any requested tone becomes current so it is not lost.
            bus.cur_tone   <= nt;
            pend           <= 1'b0;
            cnt            <= '0;
            thr            <= thr_nt;
            bus.out        <= 1'b0;
            bus.period_end <= 1'b0;
            state          <= (state == IDLE && !bus.mute && p_nt != '0) ? RUN : IDLE;
        end else if (wrap) begin
            // Threshold never exceeds P-1, so the last cycle of a period always yields a low output.
            bus.cur_tone   <= nt;
            pend           <= 1'b0;
            cnt            <= '0;
            thr            <= thr_nt;
            bus.out        <= 1'b0;
            bus.period_end <= 1'b1;
            state          <= p_nt == '0 ? IDLE : RUN;
        end else begin
            cnt            <= cnt + 1'b1;
            bus.out        <= cnt < thr;
            bus.period_end <= 1'b0;
            if (bus.tone_load) begin
                pend      <= 1'b1;
                pend_tone <= bus.tone_sel;
            end
        end
    end
endmodule

// File: tb/tb_ondra_tone_gen.sv
// tb_ondra_tone_gen: randomized scoreboard bench for ondra_tone_gen against a period-level model
module tb_ondra_tone_gen;
    localparam int CLK = 1000;
    localparam int WP  = CLK / 500;
    localparam logic [8*18-1:0] TF = {18'd60, 18'd0, 18'd1000, 18'd300,
                                      18'd400, 18'd250, 18'd100, 18'd0};
    int freq [8] = '{0, 100, 250, 400, 300, 1000, 0, 60};
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    ondra_tone_gen_if bus();
    ondra_tone_gen #(.CLK_FREQ(CLK), .CNT_W(18), .TONE_FREQS(TF), .PULSE_DIV(500)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q [$];
    // Reference model: position inside the current period counted from its start.
    logic       m_run = 1'b0, m_pend = 1'b0, e_out = 1'b0, e_pe = 1'b0;
    logic [2:0] m_tone = '0, m_pt = '0;
    int         m_idx = 0, m_len = 0, m_hi = 0;
    logic       cur_mu = 1'b0, cur_md = 1'b0;
    function automatic int per(input logic [2:0] k);
        int f = freq[k];
        if (f == 0) return 0;
        return (CLK / f < 2) ? 2 : CLK / f;
    endfunction
    function automatic int hi_len(input int p, input logic sq);
        if (sq) return p / 2;
        return (WP < p - 1) ? WP : p - 1;
    endfunction
    task automatic start_period(input logic md);
        m_len = per(m_tone);
        m_hi  = hi_len(m_len, md);
        m_idx = 0;
    endtask
    task automatic model(input logic rn, input logic [2:0] sel, input logic ld, input logic mu, input logic md);
        if (!rn) begin
            m_run = 0; m_pend = 0; m_pt = 0; m_tone = 0; e_out = 0; e_pe = 0; m_idx = 0;
        end else if (!m_run || mu) begin
            if (ld) m_tone = sel;
            else if (m_pend) m_tone = m_pt;
            m_pend = 0; e_out = 0; e_pe = 0;
            if (!m_run && !mu && per(m_tone) > 0) begin
                m_run = 1;
                start_period(md);
            end else m_run = 0;
        end else begin
            e_out = m_idx < m_hi;
            if (m_idx == m_len - 1) begin
                e_pe = 1;
                if (ld) m_tone = sel;
                else if (m_pend) m_tone = m_pt;
                m_pend = 0;
                if (per(m_tone) == 0) begin
                    m_run = 0; e_out = 0;
                end else start_period(md);
            end else begin
                e_pe = 0;
                m_idx++;
                if (ld) begin m_pend = 1; m_pt = sel; end
            end
        end
    endtask
    task automatic step(input logic rn, input logic [2:0] sel, input logic ld, input logic mu, input logic md);
        @(negedge clk);
        reset_n = rn; bus.tone_sel = sel; bus.tone_load = ld; bus.mute = mu; bus.mode = md;
        model(rn, sel, ld, mu, md);
        exp_q.push_back({e_out, m_tone, e_pe});
    endtask
    task automatic run(input int n);
        repeat (n) step(1'b1, 3'd0, 1'b0, cur_mu, cur_md);
    endtask
    task automatic load(input logic [2:0] sel);
        step(1'b1, sel, 1'b1, cur_mu, cur_md);
    endtask
    task automatic wait_idx(input int t);
        int n = 0;
        while (!(m_run && m_idx == t) && n < 100) begin
            run(1);
            n++;
        end
    endtask
    task automatic check_zero(input string name);
        checks++;
        if ({bus.out, bus.cur_tone, bus.period_end} !== 5'd0) begin
            errors++;
            $display("FAIL %s: out/tone/pe got %b/%0d/%b, want 0/0/0", name, bus.out, bus.cur_tone, bus.period_end);
        end
    endtask
    always @(posedge clk) begin
        logic [4:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({bus.out, bus.cur_tone, bus.period_end} !== e) begin
                errors++;
                $display("FAIL cycle @%0t: out/tone/pe got %b/%0d/%b, want %b/%0d/%b",
                         $time, bus.out, bus.cur_tone, bus.period_end, e[4], e[3:1], e[0]);
            end
        end
    end
    initial begin
        bus.tone_sel = 0; bus.tone_load = 0; bus.mute = 0; bus.mode = 0;
        #1 reset_n = 1'b0;
        #2 check_zero("reset_state");
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        run(5);
        // pulse mode, tone 1
        load(3'd1);
        run(30);
        // square mode, tone change mid-period
        cur_md = 1'b1;
        run(12);
        wait_idx(3);
        load(3'd2);
        run(20);
        // load in the last cycle of a period
        load(3'd1);
        run(6);
        wait_idx(9);
        load(3'd2);
        run(10);
        // last of several loads wins
        wait_idx(1);
        load(3'd7);
        load(3'd1);
        run(12);
        // mute during the high phase with a tone pending
        wait_idx(1);
        load(3'd2);
        cur_mu = 1'b1;
        run(5);
        cur_mu = 1'b0;
        run(12);
        // silence entry at the boundary
        wait_idx(2);
        load(3'd0);
        run(15);
        // pulse at clamped/short periods
        cur_md = 1'b0;
        load(3'd5);
        run(8);
        load(3'd4);
        run(10);
        // asynchronous reset mid-run
        load(3'd1);
        run(6);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        run(6);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) cur_mu = ~cur_mu;
            if ($urandom_range(0, 19) == 0) cur_md = ~cur_md;
            if ($urandom_range(0, 7) == 0) load(3'($urandom_range(0, 7)));
            else run(1);
        end
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
